// File: rtl/button_event_decoder_if.sv
// Button-side bundle: debounced level in, one-cycle control events and the held level out.
// `release` and `repeat` are reserved words, so those events carry a _pulse suffix.
interface button_event_decoder_if;
    logic btn;
    logic press;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn,
        input  press,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn,
        output press,
        output release_pulse,
        output short_press,
        output long_press,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat pulses, timed in ticks.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined; otherwise repeat is tied low.
module button_event_decoder #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DIV_W        = 17
) (
    input logic                   clk,
    input logic                   rst,
    button_event_decoder_if.slave bus
);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LongCnt = CNT_W'(LONG_TICKS);

    // Elaboration-time parameter legality checks.
    if (TICK_DIV < 2 || (64'd1 << DIV_W) <= 64'(TICK_DIV)) begin : g_bad_div
        $error("TICK_DIV must be >= 2 and fit in DIV_W bits");
    end
    if (LONG_TICKS < 1 || 64'(LONG_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_long
        $error("LONG_TICKS out of range for CNT_W");
    end
    if (REPEAT_TICKS < 1 || 64'(REPEAT_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_rep
        $error("REPEAT_TICKS out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLongHeld
    } state_e;

    state_e state;

    logic btn_q;
    logic btn_q2;
    logic rise;
    logic fall;
    logic rise_q;
    logic fall_q;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_inc;

    logic press_q;
    logic release_q;
    logic short_q;
    logic long_q;
    logic held_q;

    assign rise = btn_q & ~btn_q2;
    assign fall = ~btn_q & btn_q2;

    // Edges are registered once more so every event lands two edges after btn is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q  <= 1'b0;
            btn_q2 <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            btn_q  <= bus.btn;
            btn_q2 <= btn_q;
            rise_q <= rise;
            fall_q <= fall;
        end
    end

    // Prescaler restarts on the same edge the FSM takes the press, aligning ticks to it.
    assign tick = (div_cnt == DivLast);

    always_ff @(posedge clk) begin
        if (rst || rise_q || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign hold_inc = (hold_cnt == LongCnt) ? hold_cnt : hold_cnt + 1'b1;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RepCnt = CNT_W'(REPEAT_TICKS);

    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_inc;
    logic             repeat_q;

    assign rep_inc = rep_cnt + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            hold_cnt  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt   <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (rise_q) begin
                        press_q  <= 1'b1;
                        held_q   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= StPressed;
                    end
                end
                StPressed: begin
                    // A release on the threshold tick wins over the long press.
                    if (fall_q) begin
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        held_q    <= 1'b0;
                        state     <= StIdle;
                    end else if (tick) begin
                        hold_cnt <= hold_inc;
                        if (hold_inc == LongCnt) begin
                            long_q <= 1'b1;
                            state  <= StLongHeld;
`ifdef BUTTON_AUTOREPEAT_EN
                            rep_cnt <= '0;
`endif
                        end
                    end
                end
                StLongHeld: begin
                    if (fall_q) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        state     <= StIdle;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (tick) begin
                        if (rep_inc == RepCnt) begin
                            repeat_q <= 1'b1;
                            rep_cnt  <= '0;
                        end else begin
                            rep_cnt <= rep_inc;
                        end
                    end
`endif
                end
                default: begin
                    held_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_press   = short_q;
    assign bus.long_press    = long_q;
    assign bus.held          = held_q;
`ifdef BUTTON_AUTOREPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
`else
    assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomised scoreboard bench for button_event_decoder: a run-level model predicts event cycles,
// a negedge monitor pops and compares them and checks held every cycle.
module tb_button_event_decoder;

    localparam int unsigned TickDiv = 4;
    localparam int unsigned LongT   = 3;
    localparam int unsigned RepT    = 2;
    localparam int          LongCyc = LongT * TickDiv;
    localparam int          RepCyc  = RepT * TickDiv;
    localparam int          NoCut   = 1 << 30;

    typedef struct {
        int         cyc;
        logic [4:0] pulses;  // {press, release, short, long, repeat}
        logic       held;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .TICK_DIV    (TickDiv),
        .LONG_TICKS  (LongT),
        .REPEAT_TICKS(RepT),
        .CNT_W       (4),
        .DIV_W       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ev_t  sb[$];
    bit   exp_held[int];
    int   edge_no   = 0;
    bit   mon_en    = 1'b0;
    bit   chk_zero  = 1'b0;
    bit   final_req = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    logic [4:0] mon_got;
    logic       mon_h;
    ev_t        mon_e;

    task automatic step();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic push_ev(input int cyc, input logic [4:0] p, input logic h, input int cut);
        ev_t e;
        if (cyc < cut) begin
            e.cyc    = cyc;
            e.pulses = p;
            e.held   = h;
            sb.push_back(e);
        end
    endtask

    // btn first sampled high at edge n and held for d edges; nothing at or after edge cut.
    task automatic push_run(input int n, input int d, input int cut);
        int p;
        p = n + 2;
        push_ev(p, 5'b10000, 1'b1, cut);
        if (d > LongCyc) begin
            push_ev(p + LongCyc, 5'b00010, 1'b1, cut);
`ifdef BUTTON_AUTOREPEAT_EN
            for (int t = p + LongCyc + RepCyc; t < p + d; t += RepCyc)
                push_ev(t, 5'b00001, 1'b1, cut);
`endif
            push_ev(p + d, 5'b01000, 1'b0, cut);
        end else begin
            push_ev(p + d, 5'b01100, 1'b0, cut);
        end
        for (int c = p; c < p + d && c < cut; c++) exp_held[c] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_got = {bus.press, bus.release_pulse, bus.short_press, bus.long_press,
                       bus.repeat_pulse};
            mon_h   = exp_held.exists(edge_no) ? 1'b1 : 1'b0;
            n_checks++;
            if (bus.held === mon_h) n_pass++;
            else $display("FAIL held cyc=%0d got=%b exp=%b", edge_no, bus.held, mon_h);
            if (chk_zero) begin
                n_checks++;
                if ({mon_got, bus.held} === 6'b0) n_pass++;
                else $display("FAIL reset_zero cyc=%0d got=%b exp=000000", edge_no,
                              {mon_got, bus.held});
            end
            if (mon_got !== 5'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_pulse cyc=%0d got=%b exp=none", edge_no, mon_got);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc == edge_no && mon_e.pulses === mon_got && mon_e.held === bus.held)
                        n_pass++;
                    else
                        $display("FAIL event got cyc=%0d pulses=%b held=%b exp cyc=%0d pulses=%b held=%b",
                                 edge_no, mon_got, bus.held, mon_e.cyc, mon_e.pulses, mon_e.held);
                end
            end
            if (final_req) begin
                n_checks++;
                if (sb.size() == 0) n_pass++;
                else $display("FAIL missing_events got=%0d left exp=0 (next cyc=%0d pulses=%b)",
                              sb.size(), sb[0].cyc, sb[0].pulses);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run(input int d, input int g);
        bus.btn = 1'b1;
        push_run(edge_no + 1, d, NoCut);
        repeat (d) step();
        bus.btn = 1'b0;
        repeat (g) step();
    endtask

    initial begin
        int dirs[10] = '{6, 40, 12, 1, 11, 13, 20, 28, 29, 2};
        int n, r;
        bus.btn = 1'b0;
        rst     = 1'b1;
        step();
        mon_en   = 1'b1;
        chk_zero = 1'b1;
        @(negedge clk);
        #1 chk_zero = 1'b0;
        step();
        rst = 1'b0;
        repeat (2) step();

        foreach (dirs[i]) run(dirs[i], $urandom_range(6, 1));
        for (int i = 0; i < 15; i++) run($urandom_range(45, 1), $urandom_range(6, 1));

        // Reset five cycles after the press pulse with btn held; no release may follow.
        bus.btn = 1'b1;
        n = edge_no + 1;
        r = n + 2 + 5;
        push_run(n, 100, r);
        while (edge_no < r - 1) step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        chk_zero = 1'b1;
        @(negedge clk);
        #1 chk_zero = 1'b0;
        push_run(r + 1, 20, NoCut);
        repeat (20) step();
        bus.btn = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 5; i++) run($urandom_range(45, 1), $urandom_range(6, 1));
        repeat (20) step();

        final_req = 1'b1;
        @(negedge clk);
        #1 final_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
